// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Opcodes, FSM states, mux selects and the control bundle.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multiciclo_next_state.sv
// Combinational next-state and Moore control decode.
// Only FETCH looks at mem_ready for its IR/PC write strobes.
module multiciclo_next_state
  import mips_pkg::*;
#(
  parameter int unsigned ENABLE_JUMP     = 1,
  parameter int unsigned ENABLE_ADDI     = 1,
  parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
  input  state_t     state,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  output state_t     next,
  output logic       retire,
  output ctrl_t      ctrl
);

  logic is_mem;
  logic is_r;
  logic is_beq;
  logic is_j;
  logic is_addi;
  state_t bad_next;

  assign is_mem  = (op_code == OP_LW) ||
                   (op_code == OP_SW);
  assign is_r    = (op_code == OP_RTYPE);
  assign is_beq  = (op_code == OP_BEQ);
  assign is_j    = (ENABLE_JUMP != 0) &&
                   (op_code == OP_J);
  assign is_addi = (ENABLE_ADDI != 0) &&
                   (op_code == OP_ADDI);

  assign bad_next = (TRAP_ON_ILLEGAL != 0) ?
                    S_TRAP : S_FETCH;

  // state transition, retire strobe and control decode
  always_comb begin
    next   = state;
    retire = 1'b0;
    ctrl   = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BR;
        ctrl.alu_op    = ALU_ADD;
        unique case (1'b1)
          is_mem:  next = S_MEM_ADDR;
          is_r:    next = S_EXEC_R;
          is_beq:  next = S_BRANCH;
          is_j:    next = S_JUMP;
          is_addi: next = S_ADDI_EX;
          default: begin
            next   = bad_next;
            retire = (bad_next == S_FETCH);
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next = (op_code == OP_SW) ?
               S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) next = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        next   = S_FETCH;
        retire = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) begin
          next   = S_FETCH;
          retire = 1'b1;
        end
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        next = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        next   = S_FETCH;
        retire = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
        next   = S_FETCH;
        retire = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
        next   = S_FETCH;
        retire = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        next   = S_FETCH;
        retire = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multiciclo_control.sv
// Multicycle MIPS control FSM with retired-instruction count.
// Holds the state register and counter; decode lives below.
module multiciclo_control
  import mips_pkg::*;
#(
  parameter int unsigned ENABLE_JUMP     = 1,
  parameter int unsigned ENABLE_ADDI     = 1,
  parameter int unsigned TRAP_ON_ILLEGAL = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t cur;
  state_t nxt;
  logic   retire;
  ctrl_t  ctrl;

  multiciclo_next_state #(
    .ENABLE_JUMP     (ENABLE_JUMP),
    .ENABLE_ADDI     (ENABLE_ADDI),
    .TRAP_ON_ILLEGAL (TRAP_ON_ILLEGAL)
  ) u_next (
    .state     (cur),
    .op_code   (op_code),
    .mem_ready (mem_ready),
    .next      (nxt),
    .retire    (retire),
    .ctrl      (ctrl)
  );

  // state register; reset abandons any memory access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= S_FETCH;
    else      cur <= nxt;
  end

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUOp       = ctrl.alu_op;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign illegal     = ctrl.illegal;
  assign state       = cur;

endmodule

// File: tb/tb_multiciclo_control.sv
// Randomized bench for multiciclo_control.
// Instance a: defaults; instance b: no j/addi, NOP on illegal, 4-bit count.
module tb_multiciclo_control;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, mr_a, mr_b;
  logic [5:0] op_a, op_b;

  logic pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, m2r_a;
  logic irw_a, rw_a, rd_a, sa_a, ill_a;
  logic [1:0] aop_a, sb_a, ps_a;
  logic [3:0] st_a;
  logic [31:0] ret_a;

  logic pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, m2r_b;
  logic irw_b, rw_b, rd_b, sa_b, ill_b;
  logic [1:0] aop_b, sb_b, ps_b;
  logic [3:0] st_b;
  logic [3:0] ret_b;

  wire [16:0] obs_a = {pcw_a, pcwc_a, iord_a, mrd_a,
                       mwr_a, m2r_a, irw_a, rw_a, rd_a,
                       sa_a, aop_a, sb_a, ps_a, ill_a};
  wire [16:0] obs_b = {pcw_b, pcwc_b, iord_b, mrd_b,
                       mwr_b, m2r_b, irw_b, rw_b, rd_b,
                       sa_b, aop_b, sb_b, ps_b, ill_b};

  multiciclo_control dut_a (
    .clk(clk), .rst(rst_a), .op_code(op_a),
    .mem_ready(mr_a),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a),
    .IorD(iord_a), .MemRead(mrd_a),
    .MemWrite(mwr_a), .MemtoReg(m2r_a),
    .IRWrite(irw_a), .RegWrite(rw_a),
    .RegDst(rd_a), .ALUSrcA(sa_a),
    .ALUOp(aop_a), .ALUSrcB(sb_a),
    .PCSource(ps_a), .illegal(ill_a),
    .state(st_a), .retired(ret_a)
  );

  multiciclo_control #(
    .ENABLE_JUMP(0), .ENABLE_ADDI(0),
    .TRAP_ON_ILLEGAL(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .op_code(op_b),
    .mem_ready(mr_b),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b),
    .IorD(iord_b), .MemRead(mrd_b),
    .MemWrite(mwr_b), .MemtoReg(m2r_b),
    .IRWrite(irw_b), .RegWrite(rw_b),
    .RegDst(rd_b), .ALUSrcA(sa_b),
    .ALUOp(aop_b), .ALUSrcB(sb_b),
    .PCSource(ps_b), .illegal(ill_b),
    .state(st_b), .retired(ret_b)
  );

  int errors = 0;
  int checks = 0;
  int cnt_a  = 0;
  int cnt_b  = 0;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // expected control word for a named step
  function automatic logic [16:0] exp_ctl(state_t s,
                                          logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r;
    logic irw, rw, rd, sa, ill;
    logic [1:0] aop, sb, ps;
    {pcw, pcwc, iord, mrd, mwr, m2r} = '0;
    {irw, rw, rd, sa, ill} = '0;
    aop = 2'b00; sb = 2'b00; ps = 2'b00;
    case (s)
      S_FETCH:    begin mrd = 1; sb = 2'b01;
                        irw = mr; pcw = mr; end
      S_DECODE:   sb = 2'b11;
      S_MEM_ADDR: begin sa = 1; sb = 2'b10; end
      S_MEM_RD:   begin mrd = 1; iord = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mwr = 1; iord = 1; end
      S_EXEC_R:   begin sa = 1; aop = 2'b10; end
      S_R_WB:     begin rw = 1; rd = 1; end
      S_BRANCH:   begin sa = 1; aop = 2'b01;
                        pcwc = 1; ps = 2'b01; end
      S_JUMP:     begin pcw = 1; ps = 2'b10; end
      S_ADDI_EX:  begin sa = 1; sb = 2'b10; end
      S_ADDI_WB:  rw = 1;
      S_TRAP:     ill = 1;
      default:    ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw,
            rw, rd, sa, aop, sb, ps, ill};
  endfunction

  // one clock cycle on instance b or a
  task automatic step(bit b, logic [5:0] op,
                      logic mr, state_t es);
    if (b) begin op_b = op; mr_b = mr; end
    else   begin op_a = op; mr_a = mr; end
    @(negedge clk);
    if (b) begin
      check("state_b", 32'(st_b), 32'(es));
      check("ctl_b", 32'(obs_b), 32'(exp_ctl(es, mr)));
      check("retired_b", 32'(ret_b), 32'(cnt_b % 16));
    end else begin
      check("state_a", 32'(st_a), 32'(es));
      check("ctl_a", 32'(obs_a), 32'(exp_ctl(es, mr)));
      check("retired_a", ret_a, 32'(cnt_a));
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] bad_op();
    logic [5:0] tbl [4];
    tbl[0] = 6'b111111; tbl[1] = 6'b000011;
    tbl[2] = 6'b001101; tbl[3] = 6'b100000;
    return tbl[$urandom_range(3, 0)];
  endfunction

  // kind: 0 lw 1 sw 2 R 3 beq 4 j 5 addi 6 illegal
  task automatic run_instr(bit b, int kind,
                           int fw, int mw);
    logic [5:0] op;
    bit en_j, en_addi, trp, bad;
    int nf, nm;
    en_j = !b; en_addi = !b; trp = !b;
    case (kind)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: op = 6'b000000;
      3: op = 6'b000100;
      4: op = 6'b000010;
      5: op = 6'b001000;
      default: op = bad_op();
    endcase
    bad = (kind >= 6) || (kind == 4 && !en_j) ||
          (kind == 5 && !en_addi);
    nf = (fw < 0) ? $urandom_range(2, 0) : fw;
    nm = (mw < 0) ? $urandom_range(3, 0) : mw;
    for (int i = 0; i < nf; i++)
      step(b, 6'($urandom), 1'b0, S_FETCH);
    step(b, op, 1'b1, S_FETCH);
    step(b, op, 1'($urandom), S_DECODE);
    if (bad) begin
      if (trp) begin
        for (int i = 0; i < 10; i++)
          step(b, op, 1'($urandom), S_TRAP);
        return;
      end
    end else begin
      case (kind)
        0: begin
          step(b, op, 1'($urandom), S_MEM_ADDR);
          for (int i = 0; i < nm; i++)
            step(b, op, 1'b0, S_MEM_RD);
          step(b, op, 1'b1, S_MEM_RD);
          step(b, op, 1'($urandom), S_MEM_WB);
        end
        1: begin
          step(b, op, 1'($urandom), S_MEM_ADDR);
          for (int i = 0; i < nm; i++)
            step(b, op, 1'b0, S_MEM_WR);
          step(b, op, 1'b1, S_MEM_WR);
        end
        2: begin
          step(b, op, 1'($urandom), S_EXEC_R);
          step(b, op, 1'($urandom), S_R_WB);
        end
        3: step(b, op, 1'($urandom), S_BRANCH);
        4: step(b, op, 1'($urandom), S_JUMP);
        default: begin
          step(b, op, 1'($urandom), S_ADDI_EX);
          step(b, op, 1'($urandom), S_ADDI_WB);
        end
      endcase
    end
    if (b) cnt_b++;
    else   cnt_a++;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    mr_a = 1'b0; mr_b = 1'b0;
    op_a = '0; op_b = '0;
    #1;
    check("rst_state_a", 32'(st_a), 32'(S_FETCH));
    check("rst_ret_a", ret_a, 32'd0);
    check("rst_ill_a", 32'(ill_a), 32'd0);
    check("rst_state_b", 32'(st_b), 32'(S_FETCH));
    check("rst_ret_b", 32'(ret_b), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;

    run_instr(1'b0, 0, 0, 0);
    run_instr(1'b0, 1, 0, 3);
    run_instr(1'b0, 2, 2, 0);
    for (int n = 0; n < 40; n++)
      run_instr(1'b0, $urandom_range(5, 0), -1, -1);

    run_instr(1'b0, 6, -1, -1);
    rst_a = 1'b0;
    #1;
    check("trap_rst_state", 32'(st_a), 32'(S_FETCH));
    check("trap_rst_ret", ret_a, 32'd0);
    check("trap_rst_ill", 32'(ill_a), 32'd0);
    cnt_a = 0;
    #2 rst_a = 1'b1;

    for (int n = 0; n < 3; n++)
      run_instr(1'b0, $urandom_range(5, 0), -1, -1);
    step(1'b0, 6'b100011, 1'b1, S_FETCH);
    step(1'b0, 6'b100011, 1'b0, S_DECODE);
    step(1'b0, 6'b100011, 1'b0, S_MEM_ADDR);
    step(1'b0, 6'b100011, 1'b0, S_MEM_RD);
    rst_a = 1'b0;
    #1;
    check("abort_state", 32'(st_a), 32'(S_FETCH));
    check("abort_ret", ret_a, 32'd0);
    check("abort_memrd", 32'(mrd_a & iord_a), 32'd0);
    cnt_a = 0;

    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int n = 0; n < 16; n++)
      run_instr(1'b1, 2, -1, -1);
    check("wrap_b", 32'(ret_b), 32'd0);
    run_instr(1'b1, 4, -1, -1);
    run_instr(1'b1, 5, -1, -1);
    run_instr(1'b1, 6, -1, -1);
    for (int n = 0; n < 30; n++)
      run_instr(1'b1, $urandom_range(6, 0), -1, -1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/multiciclo_control.md
MULTICICLO_CONTROL -- requirements
Module: multiciclo_control

Interface
REQ-001 SHALL have parameter ENABLE_JUMP, default 1, meaning j opcode decoded; when 0, j is illegal.
REQ-002 SHALL have parameter ENABLE_ADDI, default 1, meaning addi opcode decoded; when 0, addi is illegal.
REQ-003 SHALL have parameter TRAP_ON_ILLEGAL, default 1, meaning 1 = enter TRAP on illegal opcode, 0 = treat as NOP.
REQ-004 SHALL have parameter CNT_W, default 32, meaning width of retired-instruction counter.
REQ-005 SHALL have port clk input 1, the single clock, all state on rising edge.
REQ-006 SHALL have port rst input 1, the reset, which is asynchronous and active-low.
REQ-007 SHALL have port op_code input 6, instruction[31:26] from IR.
REQ-008 SHALL have port mem_ready input 1, memory handshake completion; the current access finishes on a cycle where it is 1.
REQ-009 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA, each 1 bit, standard multicycle MIPS controls.
REQ-010 SHALL have outputs ALUOp 2 (00 add, 01 sub, 10 funct), ALUSrcB 2 (00 reg, 01 const 4, 10 signext, 11 signext<<2), PCSource 2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-011 SHALL have outputs illegal 1 (TRAP indicator), state 4 (current state encoding), retired CNT_W (completed-instruction count).

Function
REQ-012 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, TRAP.
REQ-013 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; it remains in FETCH while mem_ready=0 and goes to DECODE when mem_ready=1.
REQ-014 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and branch on op_code: 100011/101011 -> MEM_ADDR, 000000 -> EXEC_R, 000100 -> BRANCH, 000010 -> JUMP (if ENABLE_JUMP), 001000 -> ADDI_EX (if ENABLE_ADDI), else illegal path.
REQ-015 Illegal path SHALL go to TRAP when TRAP_ON_ILLEGAL=1, else to FETCH, counting as retired.
REQ-016 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEM_RD for lw and MEM_WR for sw.
REQ-017 MEM_RD SHALL hold MemRead=1, IorD=1 until mem_ready=1, then go to MEM_WB.
REQ-018 MEM_WB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0 for one cycle, then go to FETCH.
REQ-019 MEM_WR SHALL hold MemWrite=1, IorD=1 until mem_ready=1, then go to FETCH.
REQ-020 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10 and go to R_WB; R_WB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0 and go to FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-022 JUMP SHALL drive PCWrite=1, PCSource=10, then go to FETCH.
REQ-023 ADDI_EX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00 and go to ADDI_WB; ADDI_WB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0 and go to FETCH.
REQ-024 TRAP SHALL hold illegal=1, all write/memory enables 0, and leave only via reset.
REQ-025 Every control output not listed for a state SHALL be 0.
REQ-026 retired SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, ADDI_WB, or DECODE on the NOP path, and SHALL wrap from all-ones to 0.
REQ-027 mem_ready asserted outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-028 Outputs SHALL be decoded from state (Moore), except IRWrite/PCWrite in FETCH, which are gated by mem_ready.

Reset
REQ-029 rst=0 SHALL immediately force state=FETCH, retired=0, and illegal=0, asynchronously, including mid-access (MEM_RD/MEM_WR abandoned).
REQ-030 After rst deasserts, the first rising edge SHALL evaluate FETCH normally.

Structure
REQ-031 Opcode constants, state enum (4-bit), ALUOp/ALUSrcB/PCSource encodings SHALL live in shared package mips_pkg.
REQ-032 One sub-module, multiciclo_next_state (combinational next-state plus decode), is natural; the counter and state register SHALL stay in the top.

Verification
REQ-033 lw with mem_ready=1 always -> FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH, giving 5 cycles, retired 0->1.
REQ-034 sw with mem_ready low for 3 cycles in MEM_WR -> MemWrite high 4 cycles, then FETCH, with retired incremented once.
REQ-035 FETCH with mem_ready=0 for 2 cycles -> IRWrite/PCWrite stay 0, then pulse exactly 1 cycle when mem_ready=1.
REQ-036 op_code 111111 with TRAP_ON_ILLEGAL=1 -> TRAP, illegal=1 held 10 cycles; with TRAP_ON_ILLEGAL=0 -> FETCH, retired+1.
REQ-037 ENABLE_JUMP=0 with op_code 000010 -> illegal path, and PCWrite never asserted with PCSource=10.
REQ-038 CNT_W=4 with 16 R-type instructions -> retired wraps 15->0; rst pulse in MEM_RD -> state=FETCH and retired=0 with no clock edge.
